// File: rtl/hl_pkg.sv
// Shared types and default sizing for the hidden-layer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FETCH,
        DRAIN,
        LATCH,
        EMIT,
        DONE
    } hl_state_t;

    localparam int HL_N_IN     = 64;
    localparam int HL_N_NEURON = 16;
    localparam int HL_DW       = 10;
    localparam int HL_AW       = 20;

endpackage

// File: rtl/hl_sat_relu.sv
// Clamps a signed AW-bit accumulator value into signed DW bits; HL_RELU_EN zeroes negatives first.
// Latency: combinational.
// Backpressure: none.
module hl_sat_relu #(
    parameter int AW = 20,
    parameter int DW = 10
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [DW-1:0] result
);

    localparam logic signed [AW-1:0] MAX_V = AW'((2 ** (DW - 1)) - 1);
    // Bitwise inverse of the largest positive value is the most negative DW-bit value.
    localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

    logic signed [AW-1:0] clipped;

    // Optional rectification followed by the signed clamp.
    always_comb begin
        clipped = acc;
`ifdef HL_RELU_EN
        if (acc[AW-1]) begin
            clipped = '0;
        end
`else
`endif
        if (clipped > MAX_V) begin
            result = MAX_V[DW-1:0];
        end else if (clipped < MIN_V) begin
            result = MIN_V[DW-1:0];
        end else begin
            result = clipped[DW-1:0];
        end
    end

endmodule

// File: rtl/hidden_layer_sequencer.sv
// Sequences one hidden layer over a shared MAC: clear, N_IN reads, drain, saturate, emit per neuron.
// Latency: N_IN+4 cycles per neuron with out_ready high; N_NEURON*(N_IN+4)+1 from first CLR to done.
// Backpressure: EMIT holds out_data/out_idx until out_ready; optional ReLU via HL_RELU_EN.
module hidden_layer_sequencer
    import hl_pkg::*;
#(
    parameter int N_IN     = HL_N_IN,
    parameter int N_NEURON = HL_N_NEURON,
    parameter int DW       = HL_DW,
    parameter int AW       = HL_AW
) (
    input  logic                                Clock,
    input  logic                                Clear,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(N_IN)-1:0]             in_addr,
    output logic [$clog2(N_IN*N_NEURON)-1:0]    w_addr,
    output logic                                mem_rd,
    output logic                                mac_clr,
    output logic                                mac_en,
    input  logic signed [AW-1:0]                acc_val,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(N_NEURON)-1:0]         out_idx,
    output logic signed [DW-1:0]                out_data
);

    localparam int KW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN * N_NEURON);
    localparam int NW = $clog2(N_NEURON);

    hl_state_t            state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [NW-1:0]        n_q, n_d;
    logic [NW-1:0]        idx_q, idx_d;
    logic signed [DW-1:0] data_q, data_d;
    logic                 mac_en_q;
    logic signed [DW-1:0] sat_val;

    hl_sat_relu #(
        .AW (AW),
        .DW (DW)
    ) u_sat (
        .acc    (acc_val),
        .result (sat_val)
    );

    // State, counters and the held result.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Memory data arrives one cycle after the read strobe, so accumulate one cycle later.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= mem_rd;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        idx_d     = idx_q;
        data_d    = data_q;
        mem_rd    = 1'b0;
        mac_clr   = 1'b0;
        in_addr   = '0;
        w_addr    = '0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                mac_clr = 1'b1;
                k_d     = '0;
                state_d = FETCH;
            end
            FETCH: begin
                mem_rd  = 1'b1;
                in_addr = k_q;
                w_addr  = WW'(n_q) * WW'(N_IN) + WW'(k_q);
                k_d     = k_q + 1'b1;
                if (k_q == KW'(N_IN - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = LATCH;
            end
            LATCH: begin
                data_d  = sat_val;
                idx_d   = n_q;
                state_d = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (n_q == NW'(N_NEURON - 1)) begin
                        state_d = DONE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = CLR;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                n_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign mac_en   = mac_en_q;
    assign out_idx  = (state_q == EMIT) ? idx_q  : '0;
    assign out_data = (state_q == EMIT) ? data_q : '0;

endmodule

// File: doc/hidden_layer_sequencer.md
# hidden_layer_sequencer

Control sequencer for one hidden layer built on a single shared multiply-accumulate datapath (multiplier plus accumulator), evaluating N_NEURON neurons over N_IN inputs.
- On `start`, walks every neuron in turn:
  - clears the accumulator;
  - issues input/weight memory reads;
  - enables accumulation aligned to read data;
  - saturates the final sum (optional ReLU);
  - hands the result downstream over a valid/ready handshake.
- Sits between the input/weight memories and the next layer.

## Interface
- `N_IN`, 64: inputs per neuron (≥2)
- `N_NEURON`, 16: neurons in the layer (≥2)
- `DW`, 10: signed output data width
- `AW`, 20: signed accumulator width (AW > DW)

Ports:
- `Clock`  in  1  sole clock, rising edge
- `Clear`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin layer pass; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last result transfers
- `in_addr`  out  $clog2(N_IN)  input memory address
- `w_addr`  out  $clog2(N_IN*N_NEURON)  weight address, row-major: neuron*N_IN + k
- `mem_rd`  out  1  read strobe; memories return data one cycle later
- `mac_clr`  out  1  synchronous accumulator clear
- `mac_en`  out  1  accumulate strobe; accumulator updates at end of that cycle
- `acc_val`  in  signed AW  accumulator output
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `out_idx`  out  $clog2(N_NEURON)  neuron index of `out_data`
- `out_data`  out  signed DW  saturated result

## Operation
- States: IDLE, CLR, FETCH, DRAIN, LATCH, EMIT, DONE.
- IDLE → CLR on `start`. `start` in any other state is ignored and never queued.
- CLR (1 cycle): `mac_clr`=1. Resets `k`=0.
- FETCH (N_IN cycles):
  - `mem_rd`=1, `in_addr`=k, `w_addr`=n*N_IN+k, `k`++.
  - Exits to DRAIN when k=N_IN-1.
- `mac_en` is `mem_rd` delayed one cycle. It is therefore also high during DRAIN.
- DRAIN (1 cycle): the last product is accumulated.
- LATCH (1 cycle):
  - `out_data` ← sat(`acc_val`); `out_idx` ← n.
  - Goes to EMIT.
- EMIT: `out_valid`=1. While `out_ready`=0, `out_data`/`out_idx` are held stable. On `out_valid && out_ready`:
  - if n=N_NEURON-1 → DONE;
  - else n++ and → CLR.
- DONE (1 cycle): `done`=1, then → IDLE.
- Saturation: clamp `acc_val` to [-2^(DW-1), 2^(DW-1)-1] (DW=10: [-512, 511]).
- Outputs are driven 0 whenever not asserted by the current state. Address outputs are 0 outside FETCH.

## Timing
- Reset (`Clear`=0, any time, including mid-pass):
  - state → IDLE immediately;
  - n, k, and every output are 0;
  - the pass is abandoned; no `done`.
- With `out_ready` held high, each neuron takes N_IN+4 cycles.
- A full pass takes N_NEURON*(N_IN+4)+1 cycles from the first CLR to `done` inclusive.
- Start latency: `start` sampled high in cycle 0 → CLR in cycle 1.
- Back-to-back passes: `start` is accepted in IDLE on the cycle after DONE.

## Configuration
- `HL_RELU_EN` defined: a negative `acc_val` is forced to 0 before saturation, so `out_data` ∈ [0, 2^(DW-1)-1].
- `HL_RELU_EN` undefined: signed saturation only.

## Structure
- Shared package `hl_pkg` contains:
  - the state enum typedef `hl_state_t`;
  - default constants for N_IN, N_NEURON, DW, AW.
- Sub-module `hl_sat_relu`: combinational, AW→DW clamp plus the `HL_RELU_EN` ReLU option. It is instantiated at the LATCH register input.

## Test plan
All scenarios use N_IN=4, N_NEURON=2, DW=10, AW=20.
- Nominal pass, `out_ready`=1, start in cycle 0:
  - `mac_clr` in cycles 1 and 9;
  - `in_addr` 0..3 in cycles 2–5 and 10–13;
  - `w_addr` 0..3, then 4..7;
  - `mac_en` in cycles 3–6 and 11–14;
  - `out_valid` in cycles 8 and 16, with `out_idx` 0 then 1;
  - `done` in cycle 17; `busy` low from cycle 18.
- Saturation: `acc_val`=+700 → `out_data`=511; `acc_val`=-700 → -512 without `HL_RELU_EN`, 0 with it; `acc_val`=-3 → 0 with `HL_RELU_EN`.
- Backpressure: `out_ready`=0 for 5 cycles in the first EMIT → `out_valid` stays high, `out_data`/`out_idx` stay constant, and the second CLR occurs the cycle after `out_ready` rises.
- Reset mid-FETCH: `Clear` low in cycle 4 → all outputs 0 in that cycle, `busy`=0, no `done`. A new `start` then gives the nominal sequence.
- Ignored start: `start` pulsed in cycles 5 and 17 → no effect on sequencing or addresses. `start` in cycle 18 (IDLE) begins a new pass.
